// File: rtl/mem_responder.sv
// Wait-state memory responder: accepts one read or write in IDLE, holds it for
// WAIT_CYCLES edges in BUSY, performs the access and pulses done for one cycle.
module mem_responder #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_in,
    output logic [31:0]       Mdatain,
    output logic              done,
    output logic              busy,
    output logic              err
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [ADDR_W-1:0]  lat_addr;
    logic [DATA_W-1:0]  lat_data;
    logic               lat_wr;
    logic               lat_err;
    logic               accept;
    logic               access;
    logic               done_nxt;
    logic               busy_nxt;
    logic               err_nxt;

    logic [DATA_W-1:0]  mem [DEPTH];

    // Next-state, wait counter and next values of the registered status outputs
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        access    = 1'b0;
        unique case (state)
            IDLE: begin
                if (read || write) begin
                    accept    = 1'b1;
                    cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    access    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        done_nxt = (state_nxt == DONE);
        busy_nxt = (state_nxt != IDLE);
        err_nxt  = access && lat_err;
    end

    // State, counter, request latches and registered outputs
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_wr   <= 1'b0;
            lat_err  <= 1'b0;
            Mdatain  <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
            busy  <= busy_nxt;
            err   <= err_nxt;
            if (accept) begin
                lat_addr <= addr;
                lat_data <= data_in;
                lat_wr   <= write;
                lat_err  <= read && write;
            end
            if (access && !lat_wr) begin
                Mdatain <= mem[lat_addr];
            end
        end
    end

    // Storage is deliberately left out of reset; clear forces IDLE so no write can commit
    always_ff @(posedge clk) begin
        if (access && lat_wr) begin
            mem[lat_addr] <= lat_data;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder at WAIT_CYCLES=2 and 1, checked
// per cycle against a transaction-timing reference model.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int W = (g == 0) ? 2 : 1;

        logic        clear = 1'b1;
        logic        read = 1'b0;
        logic        write = 1'b0;
        logic [8:0]  addr = '0;
        logic [31:0] data_in = '0;
        logic [31:0] mdatain;
        logic        done;
        logic        busy;
        logic        err;
        logic        fin = 1'b0;
        logic        chk_en = 1'b0;

        mem_responder #(.ADDR_W(9), .WAIT_CYCLES(W)) u_dut (
            .clk     (clk),
            .clear   (clear),
            .read    (read),
            .write   (write),
            .addr    (addr),
            .data_in (data_in),
            .Mdatain (mdatain),
            .done    (done),
            .busy    (busy),
            .err     (err)
        );

        // Reference model: age counts edges since acceptance (-1 when idle)
        int          age = -1;
        logic        l_rd, l_wr;
        logic [8:0]  l_a;
        logic [31:0] l_d;
        logic [31:0] exp_m = '0;
        logic        m_known = 1'b1;
        logic [31:0] mm [int];

        always @(posedge clk or posedge clear) begin
            if (clear) begin
                age = -1;
                exp_m = '0;
                m_known = 1'b1;
            end else if (age < 0) begin
                if (read || write) begin
                    age = 0;
                    l_rd = read; l_wr = write; l_a = addr; l_d = data_in;
                end
            end else begin
                age++;
                if (age == W) begin
                    if (l_wr) mm[int'(l_a)] = l_d;
                    else if (mm.exists(int'(l_a))) begin
                        exp_m = mm[int'(l_a)];
                        m_known = 1'b1;
                    end else m_known = 1'b0;
                end else if (age == W + 1) begin
                    age = -1;
                end
            end
        end

        task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
            check($sformatf("w%0d %s", W, tag), o, e);
        endtask

        always @(negedge clk) begin
            if (chk_en && !clear) begin
                chk("busy", 32'(busy), 32'(age >= 0));
                chk("done", 32'(done), 32'(age == W));
                chk("err", 32'(err), 32'(age == W && l_rd && l_wr));
                if (m_known) chk("Mdatain", mdatain, exp_m);
            end
        end

        task automatic wait_idle();
            int n = 0;
            @(negedge clk);
            while (busy && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("idle reached", 32'(busy), 32'(0));
        endtask

        // Issue one access, scramble all inputs while it is in flight, release at done
        task automatic do_access(input logic rd, input logic wr, input logic [8:0] a,
                                 input logic [31:0] d);
            int n = 0;
            wait_idle();
            read = rd; write = wr; addr = a; data_in = d;
            @(negedge clk);
            while (!done && n < 50) begin
                read = 1'($urandom); write = 1'($urandom);
                addr = 9'($urandom); data_in = $urandom;
                @(negedge clk);
                n++;
            end
            chk("done seen", 32'(done), 32'(1));
            read = 1'b0; write = 1'b0;
        endtask

        task automatic held_reads(input logic [8:0] a);
            int t = 0;
            int last = -1;
            int seen = 0;
            wait_idle();
            read = 1'b1; write = 1'b0; addr = a;
            while (seen < 4 && t < 100) begin
                @(negedge clk);
                t++;
                if (done) begin
                    if (last >= 0) chk("held spacing", 32'(t - last), 32'(W + 2));
                    last = t;
                    seen++;
                end
            end
            read = 1'b0;
            chk("held count", 32'(seen), 32'(4));
        endtask

        initial begin
            logic [8:0] pool [8];
            pool = '{9'h000, 9'h001, 9'h002, 9'h0ff, 9'h100, 9'h1fe, 9'h1ff, 9'h055};
            repeat (3) @(negedge clk);
            chk("reset Mdatain", mdatain, 32'h0);
            chk("reset busy", 32'(busy), 32'(0));
            chk("reset done", 32'(done), 32'(0));
            chk("reset err", 32'(err), 32'(0));
            clear = 1'b0;
            chk_en = 1'b1;

            do_access(1'b0, 1'b1, 9'h022, 32'h4A920000);
            do_access(1'b1, 1'b0, 9'h022, 32'h0);
            chk("rd 022", mdatain, 32'h4A920000);

            do_access(1'b0, 1'b1, 9'd2, 32'h22);
            do_access(1'b0, 1'b1, 9'd4, 32'h24);
            do_access(1'b0, 1'b1, 9'd5, 32'h26);
            do_access(1'b1, 1'b0, 9'd5, 32'h0);
            chk("rd 5", mdatain, 32'h26);
            do_access(1'b1, 1'b0, 9'd2, 32'h0);
            chk("rd 2", mdatain, 32'h22);
            do_access(1'b1, 1'b0, 9'd4, 32'h0);
            chk("rd 4", mdatain, 32'h24);

            do_access(1'b1, 1'b1, 9'd7, 32'hDEADBEEF);
            chk("both err", 32'(err), 32'(1));
            chk("both done", 32'(done), 32'(1));
            do_access(1'b1, 1'b0, 9'd7, 32'h0);
            chk("rd 7", mdatain, 32'hDEADBEEF);

            do_access(1'b0, 1'b1, 9'h1ff, $urandom);
            do_access(1'b0, 1'b1, 9'h100, $urandom);
            chk("Mdatain held over writes", mdatain, 32'hDEADBEEF);

            do_access(1'b0, 1'b1, 9'd3, 32'h33333333);
            wait_idle();
            write = 1'b1; addr = 9'd3; data_in = 32'h11111111;
            @(negedge clk);
            chk("first busy cycle", 32'(busy), 32'(1));
            #1 clear = 1'b1; write = 1'b0;
            #1;
            chk("clear busy", 32'(busy), 32'(0));
            chk("clear done", 32'(done), 32'(0));
            chk("clear err", 32'(err), 32'(0));
            chk("clear Mdatain", mdatain, 32'h0);
            @(negedge clk);
            clear = 1'b0;
            do_access(1'b1, 1'b0, 9'd3, 32'h0);
            chk("rd 3 after abort", mdatain, 32'h33333333);

            held_reads(9'h022);

            repeat (150) begin
                int op;
                logic [8:0] a;
                op = $urandom_range(0, 3);
                a = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)] : 9'($urandom);
                do_access(op == 0 || op == 2 || op == 3, op == 1 || op == 2, a, $urandom);
            end
            wait_idle();
            fin = 1'b1;
        end
    end

    initial begin
        int cyc = 0;
        while (!(g_inst[0].fin && g_inst[1].fin) && cyc < 50000) begin
            @(posedge clk);
            cyc++;
        end
        check("run complete", 32'(g_inst[0].fin && g_inst[1].fin), 32'(1));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 9: address width; memory depth is 2**ADDR_W words of 32 bits.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states per access; legal range is 1..15.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port clear, input, 1: reset, asynchronous and active-high.
REQ-005 Port read, input, 1: read request, level-sensitive, sampled only in IDLE.
REQ-006 Port write, input, 1: write request, level-sensitive, sampled only in IDLE.
REQ-007 Port addr, input, ADDR_W: word address, driven from MAR.
REQ-008 Port data_in, input, 32: write data, driven from MDR.
REQ-009 Port Mdatain, output, 32: read data returned to the datapath MDR input.
REQ-010 Port done, output, 1: access-complete pulse, one cycle wide.
REQ-011 Port busy, output, 1: high whenever state is not IDLE.
REQ-012 Port err, output, 1: one-cycle pulse when read and write are accepted together.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 In IDLE with read or write high at a rising edge, the block SHALL accept the request at that edge (edge k).
- It SHALL latch addr, data_in and the operation type.
- It SHALL load the wait counter with WAIT_CYCLES-1.
- It SHALL enter BUSY.
REQ-015 In IDLE with neither read nor write high, the block SHALL stay in IDLE.
REQ-016 In BUSY, each edge with counter nonzero SHALL decrement the counter and keep the state in BUSY.
REQ-017 In BUSY, the edge with counter==0 SHALL move the state to DONE and perform the access from the latched values:
- write: mem[addr] <= data_in;
- read: Mdatain <= mem[addr].
REQ-018 done SHALL be high exactly while in DONE, i.e. for one cycle starting after edge k+WAIT_CYCLES.
REQ-019 DONE SHALL return to IDLE at the next edge unconditionally.
REQ-020 Minimum request-to-request spacing SHALL be WAIT_CYCLES+2 cycles.
REQ-021 A request held through DONE SHALL be re-accepted at the first edge in IDLE as a new access.
REQ-022 In BUSY and DONE, the read, write, addr and data_in inputs SHALL be ignored; only the latched copies are used.
REQ-023 read and write both high at acceptance: the access SHALL be treated as a write, and err SHALL pulse high during the DONE cycle.
REQ-024 Mdatain SHALL change only on read completion, holding the last read value otherwise, including across writes.
REQ-025 A read of an address written by the immediately preceding access SHALL return the new data.
REQ-026 addr SHALL use all ADDR_W bits with no aliasing; there is no out-of-range case.
REQ-027 Mdatain, done, busy and err SHALL be driven from registers; no combinational path from inputs to outputs.

Reset
REQ-028 clear high SHALL force, immediately and independent of clk:
- state to IDLE;
- counter to 0;
- Mdatain to 32'h00000000;
- done, busy and err to 0.
REQ-029 clear asserted in BUSY SHALL abort the access; a pending write SHALL NOT commit.
REQ-030 clear SHALL NOT initialise memory contents; memory is undefined until written.
REQ-031 The first request SHALL be accepted at the first rising edge after clear is released.

Verification
REQ-032 Write then read, WAIT_CYCLES=2:
- write addr=9'h022, data=32'h4A920000, held until done;
- then read addr=9'h022;
- required: each done pulses 2 edges after acceptance, and Mdatain=32'h4A920000 in the read DONE cycle.
REQ-033 Three writes then reads:
- write 32'h22, 32'h24, 32'h26 to addrs 2, 4, 5;
- read them back in the order 5, 2, 4;
- required: Mdatain sequence is 26, 22, 24, with busy high for 3 cycles per access.
REQ-034 Simultaneous request:
- read=write=1 at addr 7, data 32'hDEADBEEF;
- required: err and done pulse together, and a following read of addr 7 returns 32'hDEADBEEF.
REQ-035 Reset mid-write:
- write addr 3, data 32'h11111111;
- assert clear in the first BUSY cycle;
- required: outputs are zero at once, and a read of addr 3 returns the prior value, not 32'h11111111.
REQ-036 Input change during BUSY:
- change addr and data_in mid-access;
- required: the access uses the latched values, and Mdatain is unchanged after a write-only sequence.
REQ-037 WAIT_CYCLES=1 build:
- issue a read;
- required: done appears 1 edge after acceptance, and back-to-back held requests complete every 3 cycles.
